pack_source_arbiter: RTL and testbench



---
 rtl/pack_source_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_pack_source_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pack_source_arbiter.sv
// pack_source_arbiter
//   Shares one packet builder between N_SRC byte-stream sources. A source
//   is granted round-robin, then exactly PAYLOAD_BYTES bytes are passed
//   through combinationally to the packer. If the granted source starves
//   the packer for PAD_TIMEOUT ready cycles, the rest of the packet is
//   completed with FILL_BYTE so that the packer's framing never breaks.
//
//   Optional build macro: PACK_ARB_STATS_EN adds per-source packet counters
//   and a pad-entry counter, which are read through i_stat_sel/o_stat_count.
//   Without the macro, o_stat_count is tied to zero.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no packet in flight; arbitrate among i_req from ptr upward
//   GRANT | one cycle; clear counters, raise busy
//   XFER  | pass the granted source's bytes through to the packer
//   PAD   | source starved; drive FILL_BYTE beats until packet completes
//
// Ports
//   i_clk, i_reset   clock; asynchronous active-high reset
//   i_req[N_SRC]     source has a full payload pending
//   i_valid/i_data   per-source byte stream (source s on i_data[8s+7:8s])
//   o_ready[N_SRC]   byte accepted from source s
//   o_pack_data/o_pack_valid/i_pack_ready   byte interface to the packer
//   o_grant_id       current or last granted source
//   o_busy           packet transfer in progress
//   o_pad_pulse      one-cycle pulse on entry to PAD
//   i_stat_sel/o_stat_count   statistics readout (registered)
module pack_source_arbiter #(
  parameter int         N_SRC         = 4,
  parameter int         SIZE_BIT_PACK = 1976,
  parameter int         SIZE_PREAMBLE = 32,
  parameter int         PAYLOAD_BYTES = (SIZE_BIT_PACK - SIZE_PREAMBLE) / 8,
  parameter int         PAD_TIMEOUT   = 64,
  parameter logic [7:0] FILL_BYTE     = 8'h00,
  parameter int         ID_W          = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [N_SRC-1:0]     i_req,
  input  logic [N_SRC-1:0]     i_valid,
  input  logic [8*N_SRC-1:0]   i_data,
  output logic [N_SRC-1:0]     o_ready,
  output logic [7:0]           o_pack_data,
  output logic                 o_pack_valid,
  input  logic                 i_pack_ready,
  output logic [ID_W-1:0]      o_grant_id,
  output logic                 o_busy,
  output logic                 o_pad_pulse,
  input  logic [ID_W:0]        i_stat_sel,
  output logic [15:0]          o_stat_count
);

  localparam int CNT_W = $clog2(PAYLOAD_BYTES + 1);
  localparam int TO_W  = $clog2(PAD_TIMEOUT + 1);
  localparam int SEL_W = ID_W + 1;

  typedef enum logic [1:0] {IDLE, GRANT, XFER, PAD} state_t;

  state_t           state, state_next;
  logic [ID_W-1:0]  ptr, ptr_next, grant_id, pick_id;
  logic             pick_found;
  logic [CNT_W-1:0] byte_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             busy, pad_pulse;
  logic             g_valid;
  logic [7:0]       g_data;
  logic [N_SRC-1:0] g_mask;
  logic             beat, starve, last_beat, timeout_hit;

  assign o_grant_id  = grant_id;
  assign o_busy      = busy;
  assign o_pad_pulse = pad_pulse;

  // Round-robin pick: the requester at the smallest wrapped distance from
  // ptr wins.
  always_comb begin
    int best;
    int d;
    best       = N_SRC;
    d          = 0;
    pick_id    = '0;
    pick_found = 1'b0;
    for (int j = 0; j < N_SRC; j++) begin
      d = (j + N_SRC - int'(ptr)) % N_SRC;
      if (i_req[j] && d < best) begin
        best       = d;
        pick_id    = ID_W'(j);
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    g_mask  = '0;
    for (int j = 0; j < N_SRC; j++) begin
      if (grant_id == ID_W'(j)) begin
        g_valid   = i_valid[j];
        g_data    = i_data[8*j +: 8];
        g_mask[j] = 1'b1;
      end
    end
  end

  assign ptr_next    = ID_W'((int'(grant_id) + 1) % N_SRC);
  assign beat        = ((state == XFER && g_valid) || state == PAD) && i_pack_ready;
  // Only cycles where the packer could have taken a byte count as starved.
  assign starve      = (state == XFER) && i_pack_ready && !g_valid;
  assign last_beat   = beat && (byte_cnt == CNT_W'(PAYLOAD_BYTES - 1));
  assign timeout_hit = starve && (to_cnt == TO_W'(PAD_TIMEOUT - 1));

  always_comb begin
    state_next   = state;
    o_ready      = '0;
    o_pack_valid = 1'b0;
    o_pack_data  = '0;
    case (state)
      IDLE: begin
        if (pick_found) state_next = GRANT;
      end
      GRANT: begin
        state_next = XFER;
      end
      XFER: begin
        o_pack_valid = g_valid;
        o_pack_data  = g_data;
        o_ready      = i_pack_ready ? g_mask : '0;
        if (last_beat)        state_next = IDLE;
        else if (timeout_hit) state_next = PAD;
      end
      PAD: begin
        o_pack_valid = 1'b1;
        o_pack_data  = FILL_BYTE;
        if (last_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_id  <= '0;
      byte_cnt  <= '0;
      to_cnt    <= '0;
      busy      <= 1'b0;
      pad_pulse <= 1'b0;
    end else begin
      state     <= state_next;
      pad_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) grant_id <= pick_id;
        end
        GRANT: begin
          byte_cnt <= '0;
          to_cnt   <= '0;
          busy     <= 1'b1;
        end
        XFER, PAD: begin
          if (beat) begin
            byte_cnt <= byte_cnt + 1'b1;
            to_cnt   <= '0;
          end else if (starve && to_cnt != TO_W'(PAD_TIMEOUT)) begin
            to_cnt <= to_cnt + 1'b1;
          end
          if (timeout_hit) pad_pulse <= 1'b1;
          if (last_beat) begin
            busy <= 1'b0;
            ptr  <= ptr_next;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PACK_ARB_STATS_EN
  logic [15:0] pkt_cnt [N_SRC];
  logic [15:0] pad_cnt;
  logic [15:0] stat_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int j = 0; j < N_SRC; j++) pkt_cnt[j] <= '0;
      pad_cnt <= '0;
      stat_q  <= '0;
    end else begin
      for (int j = 0; j < N_SRC; j++) begin
        if (last_beat && grant_id == ID_W'(j) && pkt_cnt[j] != 16'hFFFF)
          pkt_cnt[j] <= pkt_cnt[j] + 1'b1;
      end
      if (timeout_hit && pad_cnt != 16'hFFFF) pad_cnt <= pad_cnt + 1'b1;
      stat_q <= '0;
      for (int j = 0; j < N_SRC; j++) begin
        if (i_stat_sel == SEL_W'(j)) stat_q <= pkt_cnt[j];
      end
      if (i_stat_sel == SEL_W'(N_SRC)) stat_q <= pad_cnt;
    end
  end

  assign o_stat_count = stat_q;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^i_stat_sel;
  assign o_stat_count    = '0;
`endif

endmodule

// File: tb/tb_pack_source_arbiter.sv
module tb_pack_source_arbiter;

  localparam int N    = 4;
  localparam int ID_W = 2;
  localparam int PB   = 243;
`ifdef PACK_ARB_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [7:0]      data;
  } exp_t;

  logic            clk;
  logic            i_reset;
  logic [N-1:0]    i_req;
  logic [N-1:0]    i_valid;
  logic [8*N-1:0]  i_data;
  logic [N-1:0]    o_ready;
  logic [7:0]      o_pack_data;
  logic            o_pack_valid;
  logic            i_pack_ready;
  logic [ID_W-1:0] o_grant_id;
  logic            o_busy;
  logic            o_pad_pulse;
  logic [ID_W:0]   i_stat_sel;
  logic [15:0]     o_stat_count;

  pack_source_arbiter #(.N_SRC(N)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_req        (i_req),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .o_pack_data  (o_pack_data),
    .o_pack_valid (o_pack_valid),
    .i_pack_ready (i_pack_ready),
    .o_grant_id   (o_grant_id),
    .o_busy       (o_busy),
    .o_pad_pulse  (o_pad_pulse),
    .i_stat_sel   (i_stat_sel),
    .o_stat_count (o_stat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  int       src_k[N];
  int       src_limit[N];
  logic [N-1:0] src_en;
  bit       bp_toggle = 0;
  bit       chk_gap = 0;

  int cyc = 0;
  int pkt_beats = 0;
  int pkts_done = 0;
  int pad_pulses = 0;
  int pulse_cyc = -1;
  int mark100 = -1;
  int last_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      i_data[8*s +: 8] = 8'(s*64 + src_k[s]);
      i_valid[s]       = src_en[s] && (src_k[s] < src_limit[s]);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(output logic [N-1:0] rdy);
    logic [N-1:0] acc;
    @(negedge clk);
    rdy = o_ready;
    acc = o_ready & i_valid;
    adv();
    for (int s = 0; s < N; s++) if (acc[s]) src_k[s]++;
    if (bp_toggle) i_pack_ready = ~i_pack_ready;
    drive();
  endtask

  task automatic push_exp(input int s, input int ndata);
    exp_t e;
    for (int j = 0; j < PB; j++) begin
      e.id   = ID_W'(s);
      e.data = (j < ndata) ? 8'(s*64 + src_k[s] + j) : 8'h00;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_req   = '0;
    src_en  = '0;
    for (int s = 0; s < N; s++) begin
      src_k[s]     = 0;
      src_limit[s] = 0;
    end
    i_pack_ready = 1'b1;
    bp_toggle    = 0;
    drive();
    repeat (3) adv();
    chk("rst_ready", int'(o_ready), 0);
    chk("rst_valid", int'(o_pack_valid), 0);
    chk("rst_data", int'(o_pack_data), 0);
    chk("rst_grant", int'(o_grant_id), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_pad_pulse", int'(o_pad_pulse), 0);
    chk("rst_stat", int'(o_stat_count), 0);
    i_reset = 1'b0;
    exp_q.delete();
    pkts_done  = 0;
    pad_pulses = 0;
    pulse_cyc  = -1;
    mark100    = -1;
    adv();
  endtask

  // Request a packet from source s with ndata valid bytes available, wait
  // for the grant, drop the requests, then wait for the packet to finish.
  task automatic run_pkt(input int s, input int ndata, input logic [N-1:0] reqs);
    logic [N-1:0] rdy;
    push_exp(s, ndata);
    src_en[s]    = 1'b1;
    src_limit[s] = src_k[s] + ndata;
    i_req        = reqs;
    drive();
    for (int t = 0; t < 10 && !o_busy; t++) begin
      cycle(rdy);
      chk("ready_before_xfer", int'(rdy), 0);
    end
    chk("grant_reached", int'(o_busy), 1);
    i_req = '0;
    for (int t = 0; t < 3000 && o_busy; t++) cycle(rdy);
    chk("pkt_finished", int'(o_busy), 0);
    chk("queue_empty", exp_q.size(), 0);
    chk("pkt_whole", pkt_beats, 0);
  endtask

  // Scoreboard monitor: every beat pops one expected byte.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (i_reset) begin
        pkt_beats = 0;
      end else begin
        if (o_pad_pulse) begin
          pad_pulses++;
          pulse_cyc = cyc;
        end
        if (o_pack_valid && i_pack_ready) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL beat_unexpected: got id=%0d data=%02h expected no beat",
                     o_grant_id, o_pack_data);
          end else begin
            e = exp_q.pop_front();
            if (o_pack_data !== e.data || o_grant_id !== e.id) begin
              n_err++;
              $display("FAIL beat_data: got id=%0d data=%02h expected id=%0d data=%02h",
                       o_grant_id, o_pack_data, e.id, e.data);
            end
          end
          if (chk_gap && pkt_beats == 0 && pkts_done > 0) begin
            n_vec++;
            if (cyc - last_cyc != 3) begin
              n_err++;
              $display("FAIL packet_gap: got %0d expected 3", cyc - last_cyc);
            end
          end
          pkt_beats++;
          if (pkt_beats == 100) mark100 = cyc;
          if (pkt_beats == PB) begin
            pkts_done++;
            pkt_beats = 0;
            last_cyc  = cyc;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rdy;
    int mk[N];
    i_reset      = 1'b1;
    i_req        = '0;
    i_valid      = '0;
    i_data       = '0;
    i_pack_ready = 1'b1;
    i_stat_sel   = '0;
    src_en       = '0;
    for (int s = 0; s < N; s++) begin
      src_k[s]     = 0;
      src_limit[s] = 0;
    end
    adv();

    // reset values, then single source packet
    do_reset();
    run_pkt(0, PB, 4'b0001);

    // reset mid-packet at byte 50 (pointer is 1 at this point)
    for (int j = 0; j < 50; j++) begin
      exp_t e;
      e.id   = 2'd1;
      e.data = 8'(64 + j);
      exp_q.push_back(e);
    end
    src_en[1]    = 1'b1;
    src_limit[1] = 1000;
    i_req        = 4'b0010;
    drive();
    for (int t = 0; t < 200 && pkt_beats < 50; t++) begin
      cycle(rdy);
      if (o_busy) i_req = '0;
    end
    chk("mid_beats", pkt_beats, 50);
    i_reset = 1'b1;
    #1;
    chk("mid_rst_valid", int'(o_pack_valid), 0);
    chk("mid_rst_ready", int'(o_ready), 0);
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_grant", int'(o_grant_id), 0);
    chk("mid_rst_data", int'(o_pack_data), 0);
    do_reset();
    src_en[1]    = 1'b1;
    src_limit[1] = 1000;
    run_pkt(0, PB, 4'b0011);

    // round robin with all sources requesting
    do_reset();
    for (int s = 0; s < N; s++) mk[s] = 0;
    for (int p = 0; p < 5; p++) begin
      int s;
      exp_t e;
      s = p % N;
      for (int j = 0; j < PB; j++) begin
        e.id   = ID_W'(s);
        e.data = 8'(s*64 + mk[s] + j);
        exp_q.push_back(e);
      end
      mk[s] += PB;
    end
    src_en = '1;
    for (int s = 0; s < N; s++) src_limit[s] = 100000;
    i_req   = '1;
    chk_gap = 1;
    drive();
    for (int t = 0; t < 1500 && pkts_done < 5; t++) begin
      cycle(rdy);
      if (pkts_done == 4 && o_busy) i_req = '0;
    end
    chk_gap = 0;
    chk("rr_packets", pkts_done, 5);
    chk("rr_queue_empty", exp_q.size(), 0);
    repeat (5) cycle(rdy);
    chk("rr_idle_after", int'(o_busy), 0);

    // packer backpressure during starvation must not trigger padding
    do_reset();
    push_exp(2, PB);
    src_limit[2] = PB;
    i_req        = 4'b0100;
    drive();
    for (int t = 0; t < 10 && !o_busy; t++) cycle(rdy);
    chk("bp_grant", int'(o_busy), 1);
    i_req     = '0;
    bp_toggle = 1;
    repeat (100) cycle(rdy);
    src_en[2] = 1'b1;
    drive();
    for (int t = 0; t < 1500 && o_busy; t++) cycle(rdy);
    bp_toggle    = 0;
    i_pack_ready = 1'b1;
    chk("bp_finished", int'(o_busy), 0);
    chk("bp_no_pad", pad_pulses, 0);
    chk("bp_queue_empty", exp_q.size(), 0);

    // starvation after 100 bytes: pad with 143 fill bytes
    do_reset();
    run_pkt(3, 100, 4'b1000);
    chk("starve_pad_pulses", pad_pulses, 1);
    chk("starve_pad_delay", pulse_cyc - mark100, 65);

    // statistics: three packets on source 1, one padded
    do_reset();
    run_pkt(1, PB, 4'b0010);
    run_pkt(1, 50, 4'b0010);
    run_pkt(1, PB, 4'b0010);
    chk("stats_pad_pulses", pad_pulses, 1);
    i_stat_sel = 3'd1;
    adv(); adv();
    chk("stat_src1", int'(o_stat_count), STATS ? 3 : 0);
    i_stat_sel = 3'd4;
    adv(); adv();
    chk("stat_pad", int'(o_stat_count), STATS ? 1 : 0);
    i_stat_sel = 3'd0;
    adv(); adv();
    chk("stat_src0", int'(o_stat_count), 0);
    i_stat_sel = 3'd7;
    adv(); adv();
    chk("stat_out_of_range", int'(o_stat_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
